branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Back end of the fetch-redirect path. Takes up to two resolved control-flow ops per cycle from execute.
//  Compares each against what the front end predicted and raises a one-cycle mispredict redirect
//  (mispredict / actual_target_address) to the fetch PC register. Queues BTB/predictor training updates.
//  Tracks an in-progress flush so wrong-path resolves are neither redirected nor trained.
// PARAMETERS
//  XLEN        32  address/data width
//  ROB_DEPTH   16  ROB entries, power of 2; ROB index width = $clog2(ROB_DEPTH)
//  UPD_DEPTH   4   training-update FIFO entries, power of 2, >=2
// PORTS
//  CLK                    in   1     clock
//  reset                  in   1     synchronous, active-high
//  rs_valid1/2            in   1     resolve slot valid (slot1 = lower slot)
//  rs_rob_idx1/2          in   RI    ROB index of resolved op
//  rs_pc1/2               in   XLEN  op PC
//  rs_is_branch1/2        in   1     conditional branch (0 = jal/jalr)
//  rs_is_ret1/2           in   1     op is a return
//  rs_pred_taken1/2       in   1     effective front-end decision (btb hit AND taken-or-jump)
//  rs_pred_target1/2      in   XLEN  front-end next-PC target when pred taken
//  rs_act_taken1/2        in   1     actual outcome (forced 1 when rs_is_branch=0)
//  rs_act_target1/2       in   XLEN  computed target
//  rob_head               in   RI    ROB head index, age reference
//  flush_done             in   1     ROB has finished squashing for current flush_rob_idx
//  upd_ready              in   1     predictor accepts an update this cycle
//  mispredict             out  1     redirect pulse to PC
//  actual_target_address  out  XLEN  correct next PC, valid with mispredict
//  flush_rob_idx          out  RI    ROB index of mispredicted op; ROB squashes younger entries
//  flushing               out  1     state == FLUSH
//  upd_valid              out  1     training update valid
//  upd_pc                 out  XLEN  PC to train
//  upd_target             out  XLEN  actual target
//  upd_taken              out  1     actual outcome
//  upd_is_branch          out  1     train direction predictor (else BTB only)
//  upd_is_ret             out  1     return flag for BTB entry
//  mispredict_count       out  32    total redirects, wraps
//  upd_drop_count         out  16    updates dropped on full FIFO, saturates at 0xFFFF
// BEHAVIOUR
//  - Reset: all outputs 0. State RUN. FIFO empty. Counters 0. Reset mid-FLUSH aborts the flush.
//  - Slot bad: correct_next = act_taken ? act_target : pc+4.
//    Bad if pred_taken != act_taken, or (act_taken && pred_target != act_target).
//  - Age: rel(i) = (rob_idx - rob_head) mod ROB_DEPTH; smaller rel = older. Wraps naturally.
//  - Slot live: RUN, valid. In FLUSH, valid AND rel < rel(flush_rob_idx); younger/equal = wrong path, ignored.
//  - Redirect: if any live slot is bad, pick the oldest bad one (slot1 on tie).
//    Next cycle: mispredict=1 for exactly 1 cycle; actual_target_address/flush_rob_idx registered.
//    Latency 1 cycle. mispredict_count++. State goes to FLUSH.
//  - A live slot younger than a bad live slot in the same cycle is wrong path: no training.
//  - FSM RUN->FLUSH on redirect. In FLUSH:
//    - an older bad live slot re-redirects (new pulse, new idx), stays FLUSH.
//    - FLUSH->RUN on flush_done with no new redirect that cycle.
//    - flush_done together with a new older redirect stays FLUSH.
//  - actual_target_address/flush_rob_idx hold last value when mispredict=0.
//  - Training: every surviving live slot is enqueued, good and bad alike; slot1 before slot2.
//    Enqueue and dequeue may occur in the same cycle; dequeue frees space first.
//    If space < needed, enqueue in order until full; drop the rest. upd_drop_count += dropped.
//  - FIFO output: registered head. upd_valid = !empty.
//    Pop when upd_valid && upd_ready. upd_* stable while upd_valid && !upd_ready.
//  - pc+4 and target compare are XLEN-bit, wrap mod 2^XLEN.
// STRUCTURE
//  - Package bp_pkg: resolve_t (pc, targets, flags, rob_idx); bp_upd_t (pc, target, taken, is_branch, is_ret);
//    enum bru_state_e {RUN, FLUSH}; function rob_age(idx, head).
//  - Sub-module bp_update_fifo: 2-in/1-out FIFO of bp_upd_t, ports push_cnt/push_data[2]/free_cnt/pop.
//  - Top holds compare/age logic, FSM, redirect registers, counters.
// TESTING
//  1. Slot1 branch pc 0x40 pred_taken=0 act_taken=1 target 0x100, idx 3
//     -> next cycle mispredict=1, target 0x100, flush_rob_idx 3, flushing=1, count=1.
//  2. head=0, slot1 idx5 bad target 0x200, slot2 idx3 bad not-taken pc 0x80
//     -> redirect to 0x84, idx 3, only slot2 update enqueued.
//  3. FLUSH idx 6: resolve idx 2 bad -> second pulse, idx 2; resolve idx 9 bad -> no pulse, no update.
//     Then flush_done -> RUN.
//  4. ROB_DEPTH 16, head 14: idx 15 and idx 1 both bad -> idx 15 chosen.
//  5. upd_ready=0, 3 cycles of 2 correct resolves -> 4 queued, upd_drop_count=2.
//     Then upd_ready=1 -> 4 pops in order, one per cycle.
//  6. reset during FLUSH with 3 queued updates -> next cycle all outputs 0, flushing=0, upd_valid=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch resolve unit shared types: resolve slot bundle, predictor update
// record, FSM state encoding and ROB age helper.
package bp_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_DEPTH = 16;
    localparam int UPD_DEPTH = 4;
    localparam int RI        = $clog2(ROB_DEPTH);

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [RI-1:0]   rob_idx_t;

    typedef struct packed {
        logic     valid;
        rob_idx_t rob_idx;
        addr_t    pc;
        addr_t    pred_target;
        addr_t    act_target;
        logic     is_branch;
        logic     is_ret;
        logic     pred_taken;
        logic     act_taken;
    } resolve_t;

    typedef struct packed {
        addr_t pc;
        addr_t target;
        logic  taken;
        logic  is_branch;
        logic  is_ret;
    } bp_upd_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    // Distance from the ROB head; modular subtraction handles wrap.
    function automatic rob_idx_t rob_age(input rob_idx_t idx,
                                         input rob_idx_t head);
        return idx - head;
    endfunction

    function automatic bp_upd_t to_upd(input resolve_t r);
        bp_upd_t u;
        u.pc        = r.pc;
        u.target    = r.act_target;
        u.taken     = r.act_taken;
        u.is_branch = r.is_branch;
        u.is_ret    = r.is_ret;
        return u;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Resolve-slot inputs, redirect outputs and predictor-update handshake.
// slave: branch_resolve_unit side; master: execute/ROB/PC/predictor side.
interface branch_resolve_unit_if;
    import bp_pkg::*;

    logic     rs_valid1,       rs_valid2;
    rob_idx_t rs_rob_idx1,     rs_rob_idx2;
    addr_t    rs_pc1,          rs_pc2;
    logic     rs_is_branch1,   rs_is_branch2;
    logic     rs_is_ret1,      rs_is_ret2;
    logic     rs_pred_taken1,  rs_pred_taken2;
    addr_t    rs_pred_target1, rs_pred_target2;
    logic     rs_act_taken1,   rs_act_taken2;
    addr_t    rs_act_target1,  rs_act_target2;
    rob_idx_t rob_head;
    logic     flush_done;
    logic     upd_ready;

    logic        mispredict;
    addr_t       actual_target_address;
    rob_idx_t    flush_rob_idx;
    logic        flushing;
    logic        upd_valid;
    addr_t       upd_pc;
    addr_t       upd_target;
    logic        upd_taken;
    logic        upd_is_branch;
    logic        upd_is_ret;
    logic [31:0] mispredict_count;
    logic [15:0] upd_drop_count;

    modport slave (
        input  rs_valid1, rs_valid2, rs_rob_idx1, rs_rob_idx2,
        input  rs_pc1, rs_pc2, rs_is_branch1, rs_is_branch2,
        input  rs_is_ret1, rs_is_ret2,
        input  rs_pred_taken1, rs_pred_taken2,
        input  rs_pred_target1, rs_pred_target2,
        input  rs_act_taken1, rs_act_taken2,
        input  rs_act_target1, rs_act_target2,
        input  rob_head, flush_done, upd_ready,
        output mispredict, actual_target_address, flush_rob_idx,
        output flushing, upd_valid, upd_pc, upd_target, upd_taken,
        output upd_is_branch, upd_is_ret,
        output mispredict_count, upd_drop_count
    );

    modport master (
        output rs_valid1, rs_valid2, rs_rob_idx1, rs_rob_idx2,
        output rs_pc1, rs_pc2, rs_is_branch1, rs_is_branch2,
        output rs_is_ret1, rs_is_ret2,
        output rs_pred_taken1, rs_pred_taken2,
        output rs_pred_target1, rs_pred_target2,
        output rs_act_taken1, rs_act_taken2,
        output rs_act_target1, rs_act_target2,
        output rob_head, flush_done, upd_ready,
        input  mispredict, actual_target_address, flush_rob_idx,
        input  flushing, upd_valid, upd_pc, upd_target, upd_taken,
        input  upd_is_branch, upd_is_ret,
        input  mispredict_count, upd_drop_count
    );

endinterface

// File: rtl/bp_update_fifo.sv
// 2-in/1-out FIFO of predictor updates. Ports: CLK, reset, push_cnt (0..2,
// already clamped to free_cnt), push_data[2], free_cnt (counts this pop), pop,
// valid (not empty), head (oldest entry, read straight from storage).
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = UPD_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [1:0]    push_cnt,
    input  bp_upd_t       push_data [2],
    output logic [CW-1:0] free_cnt,
    input  logic          pop,
    output logic          valid,
    output bp_upd_t       head
);

    bp_upd_t       mem [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_pop;

    assign valid    = (cnt_q != '0);
    assign do_pop   = pop && valid;
    assign head     = mem[rd_q];
    // A same-cycle pop makes its slot available to the pushes.
    assign free_cnt = CW'(DEPTH) - cnt_q + CW'(do_pop);

    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_cnt >= 2'd1) begin
                mem[wr_q] <= push_data[0];
            end
            if (push_cnt >= 2'd2) begin
                mem[wr_q + AW'(1)] <= push_data[1];
            end
            wr_q  <= wr_q + AW'(push_cnt);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + CW'(push_cnt) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves up to two control-flow ops per cycle, raises a one-cycle redirect
// for the oldest mispredict, tracks the flush and queues predictor training.
// Ports: CLK, reset (sync, active-high), bru (branch_resolve_unit_if.slave).
module branch_resolve_unit
    import bp_pkg::*;
(
    input logic                  CLK,
    input logic                  reset,
    branch_resolve_unit_if.slave bru
);

    localparam int FCW = $clog2(UPD_DEPTH) + 1;

    resolve_t   slot     [2];
    addr_t      next_pc  [2];
    rob_idx_t   rel      [2];
    logic       bad      [2];
    logic       live     [2];
    logic       bad_live [2];
    logic       keep     [2];
    rob_idx_t   flush_rel;
    logic       redirect;
    logic       sel;

    bru_state_e state_q, state_d;

    logic        mispredict_q;
    addr_t       target_q;
    rob_idx_t    flush_idx_q;
    logic [31:0] mp_cnt_q;
    logic [15:0] drop_cnt_q;

    bp_upd_t        push_data [2];
    logic [1:0]     need;
    logic [1:0]     push_cnt;
    logic [1:0]     drop;
    logic [FCW-1:0] free_cnt;
    logic           fifo_valid;
    logic           pop;
    bp_upd_t        fifo_head;

    always_comb begin
        slot[0].valid       = bru.rs_valid1;
        slot[0].rob_idx     = bru.rs_rob_idx1;
        slot[0].pc          = bru.rs_pc1;
        slot[0].pred_target = bru.rs_pred_target1;
        slot[0].act_target  = bru.rs_act_target1;
        slot[0].is_branch   = bru.rs_is_branch1;
        slot[0].is_ret      = bru.rs_is_ret1;
        slot[0].pred_taken  = bru.rs_pred_taken1;
        slot[0].act_taken   = bru.rs_act_taken1;
        slot[1].valid       = bru.rs_valid2;
        slot[1].rob_idx     = bru.rs_rob_idx2;
        slot[1].pc          = bru.rs_pc2;
        slot[1].pred_target = bru.rs_pred_target2;
        slot[1].act_target  = bru.rs_act_target2;
        slot[1].is_branch   = bru.rs_is_branch2;
        slot[1].is_ret      = bru.rs_is_ret2;
        slot[1].pred_taken  = bru.rs_pred_taken2;
        slot[1].act_taken   = bru.rs_act_taken2;
    end

    // Compare, age and liveness per slot. In FLUSH only ops older than
    // the op being flushed are on the correct path.
    always_comb begin
        flush_rel = rob_age(flush_idx_q, bru.rob_head);
        for (int i = 0; i < 2; i++) begin
            next_pc[i]  = slot[i].act_taken ? slot[i].act_target
                                             : slot[i].pc + addr_t'(4);
            bad[i]      = (slot[i].pred_taken != slot[i].act_taken) ||
                          (slot[i].act_taken &&
                           slot[i].pred_target != slot[i].act_target);
            rel[i]      = rob_age(slot[i].rob_idx, bru.rob_head);
            live[i]     = slot[i].valid &&
                          (state_q == RUN || rel[i] < flush_rel);
            bad_live[i] = live[i] && bad[i];
        end
        redirect = bad_live[0] || bad_live[1];
        sel      = bad_live[1] && (!bad_live[0] || rel[1] < rel[0]);
        // Anything younger than the chosen mispredict is wrong path.
        for (int i = 0; i < 2; i++) begin
            keep[i] = live[i] && (!redirect || rel[i] <= rel[sel]);
        end
    end

    // Training enqueue: slot1 first, clamp to free space, count the rest.
    always_comb begin
        push_data[0] = keep[0] ? to_upd(slot[0]) : to_upd(slot[1]);
        push_data[1] = to_upd(slot[1]);
        need         = {1'b0, keep[0]} + {1'b0, keep[1]};
        if (FCW'(need) > free_cnt) begin
            push_cnt = 2'(free_cnt);
        end else begin
            push_cnt = need;
        end
        drop = need - push_cnt;
    end

    assign pop = fifo_valid && bru.upd_ready;

    bp_update_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .free_cnt  (free_cnt),
        .pop       (pop),
        .valid     (fifo_valid),
        .head      (fifo_head)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!redirect && bru.flush_done) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            mispredict_q <= 1'b0;
            target_q     <= '0;
            flush_idx_q  <= '0;
            mp_cnt_q     <= '0;
            drop_cnt_q   <= '0;
        end else begin
            mispredict_q <= redirect;
            if (redirect) begin
                target_q    <= next_pc[sel];
                flush_idx_q <= slot[sel].rob_idx;
                mp_cnt_q    <= mp_cnt_q + 32'd1;
            end
            if (drop_cnt_q > 16'hFFFF - 16'(drop)) begin
                drop_cnt_q <= 16'hFFFF;
            end else begin
                drop_cnt_q <= drop_cnt_q + 16'(drop);
            end
        end
    end

    assign bru.mispredict            = mispredict_q;
    assign bru.actual_target_address = target_q;
    assign bru.flush_rob_idx         = flush_idx_q;
    assign bru.flushing              = (state_q == FLUSH);
    assign bru.mispredict_count      = mp_cnt_q;
    assign bru.upd_drop_count        = drop_cnt_q;
    assign bru.upd_valid             = fifo_valid;
    assign bru.upd_pc                = fifo_head.pc;
    assign bru.upd_target            = fifo_head.target;
    assign bru.upd_taken             = fifo_head.taken;
    assign bru.upd_is_branch         = fifo_head.is_branch;
    assign bru.upd_is_ret            = fifo_head.is_ret;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirect, age selection, flush
// filtering, update FIFO overflow/drain and reset during flush.
module tb_branch_resolve_unit;
    import bp_pkg::*;

    logic CLK = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_unit_if bru ();

    branch_resolve_unit dut (
        .CLK   (CLK),
        .reset (reset),
        .bru   (bru)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive1(input logic v, input logic [3:0] idx,
                          input logic [31:0] pc, input logic br,
                          input logic ret, input logic pt,
                          input logic [31:0] ptg, input logic at,
                          input logic [31:0] atg);
        bru.rs_valid1       = v;
        bru.rs_rob_idx1     = idx;
        bru.rs_pc1          = pc;
        bru.rs_is_branch1   = br;
        bru.rs_is_ret1      = ret;
        bru.rs_pred_taken1  = pt;
        bru.rs_pred_target1 = ptg;
        bru.rs_act_taken1   = at;
        bru.rs_act_target1  = atg;
    endtask

    task automatic drive2(input logic v, input logic [3:0] idx,
                          input logic [31:0] pc, input logic br,
                          input logic ret, input logic pt,
                          input logic [31:0] ptg, input logic at,
                          input logic [31:0] atg);
        bru.rs_valid2       = v;
        bru.rs_rob_idx2     = idx;
        bru.rs_pc2          = pc;
        bru.rs_is_branch2   = br;
        bru.rs_is_ret2      = ret;
        bru.rs_pred_taken2  = pt;
        bru.rs_pred_target2 = ptg;
        bru.rs_act_taken2   = at;
        bru.rs_act_target2  = atg;
    endtask

    task automatic idle();
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive2(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic finish_flush();
        bru.flush_done = 1'b1;
        tick();
        bru.flush_done = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        idle();
        bru.rob_head   = 4'd0;
        bru.flush_done = 1'b0;
        bru.upd_ready  = 1'b1;
        tick();
        tick();
        check("rst_mispredict", bru.mispredict, 0);
        check("rst_target", bru.actual_target_address, 0);
        check("rst_flushing", bru.flushing, 0);
        check("rst_upd_valid", bru.upd_valid, 0);
        check("rst_mp_count", bru.mispredict_count, 0);
        check("rst_drop_count", bru.upd_drop_count, 0);
        reset = 1'b0;
        tick();

        // 1: not-taken prediction, taken outcome
        drive1(1, 3, 32'h40, 1, 0, 0, 0, 1, 32'h100);
        tick();
        idle();
        check("t1_mispredict", bru.mispredict, 1);
        check("t1_target", bru.actual_target_address, 32'h100);
        check("t1_idx", bru.flush_rob_idx, 3);
        check("t1_flushing", bru.flushing, 1);
        check("t1_count", bru.mispredict_count, 1);
        check("t1_upd_valid", bru.upd_valid, 1);
        check("t1_upd_pc", bru.upd_pc, 32'h40);
        check("t1_upd_taken", bru.upd_taken, 1);
        tick();
        check("t1_pulse_end", bru.mispredict, 0);
        check("t1_target_hold", bru.actual_target_address, 32'h100);
        check("t1_upd_popped", bru.upd_valid, 0);
        finish_flush();
        check("t1_run", bru.flushing, 0);

        // 2: slot2 older, both bad; slot1 is wrong path
        drive1(1, 5, 32'h50, 1, 0, 0, 0, 1, 32'h200);
        drive2(1, 3, 32'h80, 1, 0, 1, 32'h300, 0, 32'h300);
        tick();
        idle();
        check("t2_mispredict", bru.mispredict, 1);
        check("t2_target", bru.actual_target_address, 32'h84);
        check("t2_idx", bru.flush_rob_idx, 3);
        check("t2_upd_pc", bru.upd_pc, 32'h80);
        check("t2_upd_taken", bru.upd_taken, 0);
        check("t2_upd_target", bru.upd_target, 32'h300);
        tick();
        check("t2_one_update", bru.upd_valid, 0);
        check("t2_count", bru.mispredict_count, 2);
        finish_flush();

        // 3: flush filtering and re-redirect
        drive1(1, 6, 32'h60, 1, 0, 0, 0, 1, 32'h600);
        tick();
        idle();
        check("t3_idx6", bru.flush_rob_idx, 6);
        check("t3_flushing", bru.flushing, 1);
        tick();
        drive1(1, 2, 32'h20, 1, 0, 1, 32'h700, 0, 32'h700);
        bru.flush_done = 1'b1;
        tick();
        idle();
        bru.flush_done = 1'b0;
        check("t3_repulse", bru.mispredict, 1);
        check("t3_idx2", bru.flush_rob_idx, 2);
        check("t3_target", bru.actual_target_address, 32'h24);
        check("t3_stay_flush", bru.flushing, 1);
        check("t3_count", bru.mispredict_count, 4);
        drive1(1, 9, 32'h90, 1, 0, 0, 0, 1, 32'h900);
        tick();
        idle();
        check("t3_young_nopulse", bru.mispredict, 0);
        check("t3_young_noupd", bru.upd_valid, 0);
        check("t3_idx_hold", bru.flush_rob_idx, 2);
        finish_flush();
        check("t3_run", bru.flushing, 0);

        // 4: age wraps around the ROB head; slot2 is a return
        bru.rob_head = 4'd14;
        drive1(1, 1, 32'h110, 1, 0, 0, 0, 1, 32'hE00);
        drive2(1, 15, 32'h150, 0, 1, 1, 32'h0, 1, 32'hF00);
        tick();
        idle();
        check("t4_idx", bru.flush_rob_idx, 15);
        check("t4_target", bru.actual_target_address, 32'hF00);
        check("t4_upd_pc", bru.upd_pc, 32'h150);
        check("t4_upd_ret", bru.upd_is_ret, 1);
        check("t4_upd_br", bru.upd_is_branch, 0);
        tick();
        check("t4_one_update", bru.upd_valid, 0);
        check("t4_count", bru.mispredict_count, 5);
        finish_flush();

        // 5: FIFO overflow then in-order drain
        bru.rob_head  = 4'd0;
        bru.upd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive1(1, 4'(2*k), 32'h1000 + 32'(8*k), 1, 0, 0, 0, 0, 0);
            drive2(1, 4'(2*k+1), 32'h1004 + 32'(8*k), 1, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        check("t5_no_redirect", bru.mispredict, 0);
        check("t5_drop", bru.upd_drop_count, 2);
        check("t5_valid", bru.upd_valid, 1);
        bru.upd_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("t5_pop_valid", bru.upd_valid, 1);
            check("t5_pop_pc", bru.upd_pc, 32'h1000 + 32'(4*j));
            tick();
        end
        check("t5_drained", bru.upd_valid, 0);

        // 7: pc+4 wraps; then 6: reset mid-flush with 3 queued
        bru.upd_ready = 1'b0;
        drive1(1, 0, 32'h2000, 1, 0, 0, 0, 0, 0);
        drive2(1, 1, 32'h2004, 1, 0, 0, 0, 0, 0);
        tick();
        idle();
        drive1(1, 4, 32'hFFFF_FFFC, 1, 0, 1, 32'h10, 0, 32'h10);
        tick();
        idle();
        check("t7_mispredict", bru.mispredict, 1);
        check("t7_wrap_target", bru.actual_target_address, 0);
        check("t7_flushing", bru.flushing, 1);
        check("t7_count", bru.mispredict_count, 6);
        check("t7_upd_head", bru.upd_pc, 32'h2000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_mispredict", bru.mispredict, 0);
        check("t6_target", bru.actual_target_address, 0);
        check("t6_idx", bru.flush_rob_idx, 0);
        check("t6_flushing", bru.flushing, 0);
        check("t6_upd_valid", bru.upd_valid, 0);
        check("t6_upd_pc", bru.upd_pc, 0);
        check("t6_mp_count", bru.mispredict_count, 0);
        check("t6_drop", bru.upd_drop_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
